// File: rtl/fpu_mds_issuer.sv
// Requester-side sequencer for the FP multiply/divide/sqrt unit: accepts one request,
// unpacks both single operands, runs the unit with a watchdog and returns a tagged result.
module fpu_mds_issuer #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  // Both request and response channels transfer on a cycle where valid && ready
  // are high at the rising clock edge; valid holds its payload stable until then.
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [2:0]       req_rm,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [4:0]       resp_flags,
  output logic [TAG_W-1:0] resp_tag,
  input  logic             fflags_clr,
  output logic [4:0]       acc_fflags,
  output logic             busy,
  output logic             timeout_err,
  output logic [1:0]       state_dbg,
  output logic             mds_start,
  output logic [1:0]       mds_op,
  output logic [2:0]       mds_rm,
  output logic             sign_A,
  output logic             sign_B,
  output logic [7:0]       exp_A,
  output logic [7:0]       exp_B,
  output logic [23:0]      sig_A,
  output logic [23:0]      sig_B,
  output logic             isZeroA,
  output logic             isZeroB,
  output logic             isInfA,
  output logic             isInfB,
  output logic             isNaNA,
  output logic             isNaNB,
  output logic             isSignaling,
  output logic             subnormal_sqrt_in,
  input  logic [31:0]      mds_out,
  input  logic             mds_done,
  input  logic             overflow,
  input  logic             underflow,
  input  logic             invalid,
  input  logic             inexact,
  input  logic             div_by_zero
);

  localparam int          CNT_W = $clog2(TIMEOUT);
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;
  localparam logic [4:0]  NV    = 5'b10000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [2:0]         rm_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [TAG_W-1:0]   tag_q;
  logic [CNT_W-1:0]   wd_cnt;
  logic               resp_first;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      op_q        <= '0;
      rm_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      wd_cnt      <= '0;
      resp_first  <= 1'b0;
      mds_start   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_flags  <= '0;
      resp_tag    <= '0;
      acc_fflags  <= '0;
      timeout_err <= 1'b0;
    end else begin
      mds_start  <= 1'b0;
      resp_first <= 1'b0;
      // Accumulate on the first response cycle; a clear in that same cycle keeps only the new flags.
      if (resp_first)
        acc_fflags <= fflags_clr ? resp_flags : (acc_fflags | resp_flags);
      else if (fflags_clr)
        acc_fflags <= '0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            rm_q  <= req_rm;
            a_q   <= req_a;
            b_q   <= req_b;
            tag_q <= req_tag;
            if (req_op == 2'b11) begin
              resp_data  <= QNAN;
              resp_flags <= NV;
              resp_tag   <= req_tag;
              resp_valid <= 1'b1;
              resp_first <= 1'b1;
              state      <= RESP;
            end else begin
              mds_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (mds_done) begin
            resp_data  <= mds_out;
            resp_flags <= {invalid, div_by_zero, overflow, underflow, inexact};
            resp_tag   <= tag_q;
            resp_valid <= 1'b1;
            resp_first <= 1'b1;
            state      <= RESP;
          end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
            resp_data   <= QNAN;
            resp_flags  <= NV;
            resp_tag    <= tag_q;
            resp_valid  <= 1'b1;
            resp_first  <= 1'b1;
            timeout_err <= 1'b1;
            state       <= RESP;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign mds_op    = op_q;
  assign mds_rm    = rm_q;

  // Operand fields are only driven while the unit owns them; elsewhere they read as zero.
  logic       opnd_vld;
  logic       is_sqrt;
  logic       b_vld;
  logic [7:0] ea, eb;
  logic       fa_nz, fb_nz;
  logic       nan_a, nan_b;

  assign opnd_vld = (state == ISSUE) || (state == WAIT);
  assign is_sqrt  = (op_q == 2'b10);
  assign b_vld    = opnd_vld && !is_sqrt;
  assign ea       = a_q[30:23];
  assign eb       = b_q[30:23];
  assign fa_nz    = |a_q[22:0];
  assign fb_nz    = |b_q[22:0];
  assign nan_a    = (ea == 8'hFF) && fa_nz;
  assign nan_b    = (eb == 8'hFF) && fb_nz;

  assign sign_A  = opnd_vld && a_q[31];
  assign exp_A   = opnd_vld ? ea : 8'h00;
  assign sig_A   = opnd_vld ? {|ea, a_q[22:0]} : 24'h0;
  assign isZeroA = opnd_vld && (ea == 8'h00) && !fa_nz;
  assign isInfA  = opnd_vld && (ea == 8'hFF) && !fa_nz;
  assign isNaNA  = opnd_vld && nan_a;

  assign sign_B  = b_vld && b_q[31];
  assign exp_B   = b_vld ? eb : 8'h00;
  assign sig_B   = b_vld ? {|eb, b_q[22:0]} : 24'h0;
  assign isZeroB = b_vld && (eb == 8'h00) && !fb_nz;
  assign isInfB  = b_vld && (eb == 8'hFF) && !fb_nz;
  assign isNaNB  = b_vld && nan_b;

  // A NaN is signaling when its quiet bit (frac msb) is clear.
  assign isSignaling       = (opnd_vld && nan_a && !a_q[22]) || (b_vld && nan_b && !b_q[22]);
  assign subnormal_sqrt_in = opnd_vld && is_sqrt && (ea == 8'h00) && fa_nz;

endmodule

// File: tb/tb_fpu_mds_issuer.sv
// Directed bench for fpu_mds_issuer: a transaction-level model checked every cycle,
// a simple FP unit responder, and literal expectations for each scenario.
module tb_fpu_mds_issuer;

  localparam int TAG_W = 5;
  localparam int TO    = 64;
  localparam int W     = 32 + 5 + TAG_W;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready;
  logic [1:0]       req_op;
  logic [2:0]       req_rm;
  logic [31:0]      req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid, resp_ready;
  logic [31:0]      resp_data;
  logic [4:0]       resp_flags;
  logic [TAG_W-1:0] resp_tag;
  logic             fflags_clr;
  logic [4:0]       acc_fflags;
  logic             busy, timeout_err;
  logic [1:0]       state_dbg;
  logic             mds_start;
  logic [1:0]       mds_op;
  logic [2:0]       mds_rm;
  logic             sign_A, sign_B;
  logic [7:0]       exp_A, exp_B;
  logic [23:0]      sig_A, sig_B;
  logic             isZeroA, isZeroB, isInfA, isInfB, isNaNA, isNaNB;
  logic             isSignaling, subnormal_sqrt_in;
  logic [31:0]      mds_out = '0;
  logic             mds_done = 1'b0;
  logic             overflow = 1'b0, underflow = 1'b0, invalid = 1'b0;
  logic             inexact = 1'b0, div_by_zero = 1'b0;

  fpu_mds_issuer #(.TAG_W(TAG_W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rm(req_rm),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_flags(resp_flags), .resp_tag(resp_tag),
    .fflags_clr(fflags_clr), .acc_fflags(acc_fflags), .busy(busy),
    .timeout_err(timeout_err), .state_dbg(state_dbg),
    .mds_start(mds_start), .mds_op(mds_op), .mds_rm(mds_rm),
    .sign_A(sign_A), .sign_B(sign_B), .exp_A(exp_A), .exp_B(exp_B),
    .sig_A(sig_A), .sig_B(sig_B),
    .isZeroA(isZeroA), .isZeroB(isZeroB), .isInfA(isInfA), .isInfB(isInfB),
    .isNaNA(isNaNA), .isNaNB(isNaNB),
    .isSignaling(isSignaling), .subnormal_sqrt_in(subnormal_sqrt_in),
    .mds_out(mds_out), .mds_done(mds_done),
    .overflow(overflow), .underflow(underflow), .invalid(invalid),
    .inexact(inexact), .div_by_zero(div_by_zero)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FP unit responder ----------------
  int          unit_delay = 1;     // 0 = never signals done
  logic [31:0] unit_out   = '0;
  logic [4:0]  unit_flags = '0;    // {NV,DZ,OF,UF,NX}
  int          u_cd = 0;

  always @(negedge clk) begin
    if (!reset) begin
      u_cd     = 0;
      mds_done = 1'b0;
    end else begin
      mds_done = 1'b0;
      if (mds_start) u_cd = unit_delay;
      else if (u_cd > 0) begin
        u_cd--;
        if (u_cd == 0) begin
          mds_done = 1'b1;
          mds_out  = unit_out;
          {invalid, div_by_zero, overflow, underflow, inexact} = unit_flags;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [35:0] side_fields(input logic [31:0] x);
    logic [7:0]  e = x[30:23];
    logic [22:0] f = x[22:0];
    return {x[31], e, {(e != 8'd0), f}, (e == 8'd0 && f == 23'd0),
            (e == 8'hFF && f == 23'd0), (e == 8'hFF && f != 23'd0)};
  endfunction

  function automatic logic snan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0) && !x[22];
  endfunction

  function automatic logic [78:0] unpack_model(input logic [1:0] op, input logic [2:0] rm,
                                               input logic [31:0] a, input logic [31:0] b);
    logic        sq  = (op == 2'd2);
    logic [35:0] bsd = sq ? 36'd0 : side_fields(b);
    logic        sig = snan(a) || (!sq && snan(b));
    logic        sub = sq && (a[30:23] == 8'd0) && (a[22:0] != 23'd0);
    return {side_fields(a), bsd, sig, sub, op, rm};
  endfunction

  logic [78:0] dut_unpack;
  assign dut_unpack = {sign_A, exp_A, sig_A, isZeroA, isInfA, isNaNA,
                       sign_B, exp_B, sig_B, isZeroB, isInfB, isNaNB,
                       isSignaling, subnormal_sqrt_in, mds_op, mds_rm};

  // Model phases: 0 idle, 1 operation in flight, 2 response offered.
  logic [W-1:0] exp_q[$];
  int           m_phase = 0, m_cyc = 0, m_resp_cyc = 0;
  logic         m_first = 1'b0, m_to_pend = 1'b0, m_to_err = 1'b0;
  logic [4:0]   m_acc = '0, m_head_flags;
  logic [78:0]  m_unpack = '0;
  logic [31:0]  m_data;
  logic [4:0]   m_flags;

  always @(negedge clk) begin
    if (!reset) begin
      m_phase  = 0;
      m_first  = 1'b0;
      m_acc    = '0;
      m_to_err = 1'b0;
      exp_q.delete();
    end else begin
      if (m_phase == 1) begin
        m_cyc++;
        if (m_cyc == m_resp_cyc) begin
          m_phase = 2;
          m_first = 1'b1;
          if (m_to_pend) m_to_err = 1'b1;
        end
      end
      check("req_ready", req_ready, m_phase == 0);
      check("busy", busy, m_phase != 0);
      check("mds_start", mds_start, m_phase == 1 && m_cyc == 1);
      check("resp_valid", resp_valid, m_phase == 2);
      if (m_phase == 2 && exp_q.size() > 0)
        check("resp_payload", {resp_data, resp_flags, resp_tag}, exp_q[0]);
      if (m_phase == 1) check("unpack", dut_unpack, m_unpack);
      check("acc_fflags", acc_fflags, m_acc);
      check("timeout_err", timeout_err, m_to_err);
      // effects of the coming rising edge
      m_head_flags = (exp_q.size() > 0) ? exp_q[0][TAG_W+4:TAG_W] : 5'd0;
      if (m_phase == 2 && m_first) begin
        m_acc   = fflags_clr ? m_head_flags : (m_acc | m_head_flags);
        m_first = 1'b0;
      end else if (fflags_clr) m_acc = '0;
      if (m_phase == 2 && resp_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_phase = 0;
      end else if (m_phase == 0 && req_valid) begin
        m_phase   = 1;
        m_cyc     = 0;
        m_unpack  = unpack_model(req_op, req_rm, req_a, req_b);
        m_to_pend = (req_op != 2'd3) && (unit_delay == 0);
        if (req_op == 2'd3) begin
          m_data = QNAN; m_flags = 5'b10000; m_resp_cyc = 1;
        end else if (unit_delay == 0) begin
          m_data = QNAN; m_flags = 5'b10000; m_resp_cyc = TO + 2;
        end else begin
          m_data = unit_out; m_flags = unit_flags; m_resp_cyc = unit_delay + 2;
        end
        exp_q.push_back({m_data, m_flags, req_tag});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [1:0] op, input logic [2:0] rm, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag);
    bit ok = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_rm = rm; req_a = a; req_b = b; req_tag = tag;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    check("req_accept_in_time", ok, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rv(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    check("resp_valid_in_time", resp_valid, 1'b1);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 fflags_clr = 1'b1;
    @(posedge clk); #1 fflags_clr = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  int n;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_op = '0; req_rm = '0; req_a = '0; req_b = '0;
    req_tag = '0; resp_ready = 1'b1; fflags_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_outputs", {busy, resp_valid, mds_start, acc_fflags, timeout_err, state_dbg}, '0);
    check("rst_resp", {resp_data, resp_flags, resp_tag}, '0);
    check("rst_unpack", dut_unpack, '0);
    @(posedge clk); #3 reset = 1'b1;

    // FMUL 2.0 x 3.0
    unit_delay = 3; unit_out = 32'h40C0_0000; unit_flags = 5'b00000;
    send_req(2'd0, 3'd0, 32'h4000_0000, 32'h4040_0000, 5'h0A);
    @(negedge clk);
    check("fmul_start", mds_start, 1'b1);
    check("fmul_exp_sig", {exp_A, sig_A, exp_B, sig_B}, {8'h80, 24'h800000, 8'h80, 24'hC00000});
    @(negedge clk);
    check("fmul_start_one_cycle", mds_start, 1'b0);
    wait_rv(n);
    check("fmul_latency", n, 3);
    check("fmul_resp", {resp_data, resp_flags, resp_tag}, {32'h40C0_0000, 5'b00000, 5'h0A});

    // FSQRT of the smallest subnormal; B side must read zero
    unit_delay = 2; unit_out = 32'h1A35_04F3; unit_flags = 5'b00001;
    send_req(2'd2, 3'd2, 32'h0000_0001, 32'h4040_0000, 5'h11);
    @(negedge clk);
    check("fsqrt_a", {subnormal_sqrt_in, sig_A, exp_A, isZeroA}, {1'b1, 24'h000001, 8'h00, 1'b0});
    check("fsqrt_b_zero", {sign_B, exp_B, sig_B, isZeroB, isInfB, isNaNB}, '0);
    wait_rv(n);
    check("fsqrt_resp", {resp_data, resp_flags, resp_tag}, {32'h1A35_04F3, 5'b00001, 5'h11});
    @(negedge clk);
    check("fsqrt_acc", acc_fflags, 5'b00001);
    pulse_clr();
    @(negedge clk);
    check("clr_alone_acc", acc_fflags, 5'b00000);

    // FDIV with a signaling NaN dividend
    unit_delay = 4; unit_out = QNAN; unit_flags = 5'b10000;
    send_req(2'd1, 3'd1, 32'h7F80_0001, 32'h3F80_0000, 5'h03);
    @(negedge clk);
    check("fdiv_nan", {isNaNA, isSignaling, isNaNB}, 3'b110);
    wait_rv(n);
    check("fdiv_flags", resp_flags, 5'b10000);
    @(negedge clk);
    check("fdiv_acc", acc_fflags, 5'b10000);

    // Backpressure with a flag clear in the response's first cycle
    @(posedge clk); #1 resp_ready = 1'b0;
    unit_delay = 3; unit_out = 32'h3F80_0000; unit_flags = 5'b00001;
    send_req(2'd0, 3'd1, 32'h3F80_0000, 32'h3F80_0000, 5'h15);
    repeat (4) @(posedge clk);
    #1 fflags_clr = 1'b1;
    @(negedge clk);
    check("bp_rise", resp_valid, 1'b1);
    @(posedge clk); #1 fflags_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {resp_valid, req_ready, resp_data, resp_flags, resp_tag},
            {1'b1, 1'b0, 32'h3F80_0000, 5'b00001, 5'h15});
      check("bp_acc_new_wins", acc_fflags, 5'b00001);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_released", req_ready, 1'b1);

    // Illegal op: immediate NaN response, no start
    send_req(2'd3, 3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'h1F);
    @(negedge clk);
    check("illegal_resp", {resp_valid, mds_start, resp_data, resp_flags, resp_tag},
          {1'b1, 1'b0, QNAN, 5'b10000, 5'h1F});

    // Watchdog abort
    unit_delay = 0;
    send_req(2'd1, 3'd0, 32'h3F80_0000, 32'h4000_0000, 5'h07);
    wait_rv(n);
    check("timeout_latency", n, TO + 2);
    check("timeout_resp", {resp_data, resp_flags, timeout_err}, {QNAN, 5'b10000, 1'b1});

    // Reset while waiting on the unit
    send_req(2'd0, 3'd0, 32'h4000_0000, 32'h4000_0000, 5'h02);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("rst_mid_idle", {req_ready, busy, resp_valid, mds_start}, 4'b1000);
    check("rst_mid_sticky", {acc_fflags, timeout_err}, 6'd0);
    @(posedge clk); #3 reset = 1'b1;
    @(negedge clk);
    check("rst_mid_after", {req_ready, resp_valid}, 2'b10);

    // Minimum-latency operation after reset
    unit_delay = 1; unit_out = 32'h4080_0000; unit_flags = 5'b00000;
    send_req(2'd0, 3'd3, 32'h4000_0000, 32'h4000_0000, 5'h09);
    wait_rv(n);
    check("min_latency", n, 3);
    check("min_resp", {resp_data, resp_tag}, {32'h4080_0000, 5'h09});
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_time_limit: got expired expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_mds_issuer.md
Name: fpu_mds_issuer

Overview:
- Requester-side sequencer for the FPU multiply/divide/sqrt unit.
- Accepts an FMUL/FDIV/FSQRT request from the FP pipeline over valid/ready and unpacks both IEEE-754 single operands into the unit's classified field inputs.
- Pulses start, waits for done, then captures the result and exception flags.
- Returns a tagged response over valid/ready and maintains sticky accumulated fflags.

Parameters:
- TAG_W, 5, width of request/response tag.
- TIMEOUT, 64, cycles in WAIT before watchdog abort (must be ≥ 2).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  issuer can accept a request
- req_op  in  2  00 FMUL, 01 FDIV, 10 FSQRT, 11 illegal
- req_rm  in  3  rounding mode
- req_a, req_b  in  32  raw single operands (req_b ignored for FSQRT)
- req_tag  in  TAG_W  request tag
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_data  out  32  result
- resp_flags  out  5  {NV,DZ,OF,UF,NX}
- resp_tag  out  TAG_W  echoed tag
- fflags_clr  in  1  clear accumulated flags
- acc_fflags  out  5  sticky OR of all returned resp_flags
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky; set on watchdog abort, cleared only by reset
- mds_start  out  1  start pulse to unit
- mds_op  out  2  latched op
- mds_rm  out  3  latched rounding mode
- sign_A, sign_B  out  1  operand signs
- exp_A, exp_B  out  8  raw exponent fields
- sig_A, sig_B  out  24  {exp!=0, frac}
- isZeroA/B, isInfA/B, isNaNA/B  out  1  classification
- isSignaling  out  1  any relevant operand is sNaN
- subnormal_sqrt_in  out  1  FSQRT operand A subnormal
- mds_out  in  32  unit result
- mds_done  in  1  unit done
- overflow, underflow, invalid, inexact, div_by_zero  in  1  unit exception flags

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready=1; operand registers, tag, resp_*, acc_fflags, and timeout_err all 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch op, rm, a, b, tag.
  - op 11 → RESP directly with resp_data=0x7FC00000, flags NV (5'b10000); no start issued.
  - Otherwise → ISSUE.
- Unpack is combinational from the latched registers and held stable from acceptance until leaving WAIT:
  - isZero: exp==0 && frac==0.
  - isInf: exp==FF && frac==0.
  - isNaN: exp==FF && frac!=0.
  - sNaN: isNaN && frac[22]==0.
  - isSignaling: sNaN(A) || (op!=FSQRT && sNaN(B)).
  - subnormal_sqrt_in: op==FSQRT && exp_A==0 && frac_A!=0.
  - For FSQRT, all B-side outputs are 0.
- ISSUE: mds_start=1 for exactly one cycle → WAIT; watchdog counter cleared.
- WAIT:
  - mds_done is sampled only in WAIT and ignored in all other states.
  - On mds_done: capture resp_data=mds_out and resp_flags={invalid,div_by_zero,overflow,underflow,inexact} → RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without done: resp_data=0x7FC00000, flags NV, timeout_err=1 → RESP.
- RESP:
  - resp_valid=1; data, flags, and tag held stable until resp_ready.
  - On resp_valid && resp_ready → IDLE. The next request can be accepted the following cycle; there is no same-cycle re-accept.
- Latency, accept at cycle 0: start at cycle 1; done sampled at cycle ≥2; resp_valid asserts the cycle after done. Minimum 3 cycles accept-to-resp_valid.
- acc_fflags updates on the cycle resp_valid rises:
  - acc |= resp_flags.
  - With fflags_clr in the same cycle, acc = resp_flags (the new flags win).
  - fflags_clr alone → acc = 0.
- Reset asserted mid-operation asynchronously forces IDLE; any in-flight result is dropped and no response is issued. The unit shares the same reset.
- busy = (state != IDLE).

Test Plan:
- FMUL 0x40000000 × 0x40400000, model returns 0x40C00000 with done 3 cycles after start → exp_A=0x80, sig_A=0x800000, exp_B=0x80, sig_B=0xC00000, one-cycle mds_start; resp_data=0x40C00000, flags 0, tag echoed.
- FSQRT a=0x00000001 → subnormal_sqrt_in=1, sig_A=0x000001, exp_A=0, isZeroA=0, B-side outputs all 0.
- FDIV a=0x7F800001, b=0x3F800000 → isNaNA=1, isSignaling=1; model returns 0x7FC00000 with invalid → resp_flags=5'b10000, acc_fflags=5'b10000.
- Model never asserts done → after TIMEOUT cycles in WAIT, resp_data=0x7FC00000, NV set, timeout_err=1.
- Backpressure: resp_ready=0 for 5 cycles → resp_data/flags/tag stable, req_ready=0; fflags_clr pulsed in the resp_valid rising cycle → acc_fflags equals that response's flags.
- op 11 → resp_valid 1 cycle after accept, mds_start never pulses. Reset asserted during WAIT → next cycle IDLE, resp_valid=0, req_ready=1, acc_fflags=0.
